// File: rtl/orv64_typedef_pkg.sv
// Shared ITB types: address/data widths of the trace RAM, controller state
// encoding and the instruction-size constants used by the PC predictor.
package orv64_typedef_pkg;

  typedef logic [7:0]  orv64_itb_addr_t;
  typedef logic [38:0] orv64_itb_data_t;

  typedef enum logic [1:0] {
    ITB_IDLE   = 2'd0,
    ITB_RUN    = 2'd1,
    ITB_POST   = 2'd2,
    ITB_FROZEN = 2'd3
  } orv64_itb_state_e;

  localparam int unsigned ORV64_ITB_INST_BYTES = 4;
  localparam int unsigned ORV64_ITB_RVC_BYTES  = 2;

endpackage : orv64_typedef_pkg

// File: rtl/orv64_itb_filter.sv
// Commit-stream filter: predicts the next sequential PC and flags commits
// that must be recorded (every commit, the first after enable, or any
// control-flow discontinuity in discontinuity-only mode).
module orv64_itb_filter
  import orv64_typedef_pkg::*;
#(
  parameter int unsigned PC_W = $bits(orv64_itb_data_t)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            active_i,        // tracing (RUN/POST) and not being cleared
  input  logic            mode_i,          // 0: all commits, 1: discontinuities only
  input  logic            set_first_i,     // entering RUN: next commit always records
  input  logic            clr_first_i,     // restart pulse
  input  logic            commit_valid_i,
  input  logic [PC_W-1:0] commit_pc_i,
  input  logic            commit_is_rvc_i,
  output logic            qual_o
);

  logic [PC_W-1:0] exp_pc_q, exp_pc_d;
  logic            first_q;
  logic            track;

  assign track = active_i & commit_valid_i;

  // Sequential successor of the retiring instruction, wrapping at 2**PC_W.
  always_comb begin
    // NOTE: combinational blocks use blocking '='; only flops use '<='.
    exp_pc_d = commit_pc_i + (commit_is_rvc_i ? PC_W'(ORV64_ITB_RVC_BYTES)
                                              : PC_W'(ORV64_ITB_INST_BYTES));
  end

  // Predicted-PC and first-commit flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_pc_q <= '0;
      first_q  <= 1'b0;
    end else begin
      if (clr_first_i)      first_q <= 1'b0;
      else if (set_first_i) first_q <= 1'b1;
      else if (track)       first_q <= 1'b0;
      if (track) exp_pc_q <= exp_pc_d;
    end
  end

  assign qual_o = track & (~mode_i | first_q | (commit_pc_i != exp_pc_q));

endmodule : orv64_itb_filter

// File: rtl/orv64_itb_ctrl.sv
// ITB write controller: filters the commit stream, drives the write port of
// the trace RAM with a wrapping pointer, and freezes a configurable number of
// entries after a trigger so the debugger sees a stable history.
module orv64_itb_ctrl
  import orv64_typedef_pkg::*;
#(
  parameter int unsigned ADDR_W = $bits(orv64_itb_addr_t),
  parameter int unsigned PC_W   = $bits(orv64_itb_data_t)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_itb_en,
  input  logic              cfg_itb_mode,
  input  logic [ADDR_W-1:0] cfg_post_trig_cnt,
  input  logic              trig,
  input  logic              clr,
  input  logic              commit_valid,
  input  logic [PC_W-1:0]   commit_pc,
  input  logic              commit_is_rvc,
  input  logic              dbg_busy,
  output logic              itb_en,
  output logic [ADDR_W-1:0] itb_addr,
  output logic [PC_W-1:0]   itb_data,
  output logic [ADDR_W-1:0] itb_wptr,
  output logic              itb_wrapped,
  output logic              itb_frozen,
  output logic              itb_drop
);

  orv64_itb_state_e  state_q, state_d;
  logic [ADDR_W-1:0] post_cnt_q, post_cnt_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] addr_q;
  logic [PC_W-1:0]   data_q;
  logic              en_q, wrapped_q, drop_q;

  logic active, set_first, qual, issue, lost;

  assign active    = ((state_q == ITB_RUN) || (state_q == ITB_POST)) && !clr;
  assign set_first = (state_q == ITB_IDLE) && cfg_itb_en && !clr;
  assign issue     = qual & ~dbg_busy;
  assign lost      = qual &  dbg_busy;

  orv64_itb_filter #(.PC_W(PC_W)) u_filter (
    .clk             (clk),
    .rst             (rst),
    .active_i        (active),
    .mode_i          (cfg_itb_mode),
    .set_first_i     (set_first),
    .clr_first_i     (clr),
    .commit_valid_i  (commit_valid),
    .commit_pc_i     (commit_pc),
    .commit_is_rvc_i (commit_is_rvc),
    .qual_o          (qual)
  );

  // Next-state and post-trigger counter; clr overrides everything.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path infers a latch.
    state_d    = state_q;
    post_cnt_d = post_cnt_q;
    unique case (state_q)
      ITB_IDLE: begin
        if (cfg_itb_en) state_d = ITB_RUN;
      end
      ITB_RUN: begin
        if (!cfg_itb_en) begin
          state_d = ITB_IDLE;
        end else if (trig) begin
          // An entry issued alongside the trigger is pre-trigger history.
          post_cnt_d = cfg_post_trig_cnt;
          state_d    = (cfg_post_trig_cnt == '0) ? ITB_FROZEN : ITB_POST;
        end
      end
      ITB_POST: begin
        if (issue) post_cnt_d = post_cnt_q - ADDR_W'(1);
        if (!cfg_itb_en) begin
          state_d = ITB_IDLE;
        end else if (issue && (post_cnt_q == ADDR_W'(1))) begin
          state_d = ITB_FROZEN;
        end
      end
      ITB_FROZEN: begin
        state_d = ITB_FROZEN;
      end
      default: state_d = ITB_IDLE;
    endcase
    if (clr) begin
      state_d    = ITB_IDLE;
      post_cnt_d = '0;
    end
  end

  // Write pointer advances only on issued entries and is zeroed by clr.
  always_comb begin
    wptr_d = wptr_q;
    if (clr)        wptr_d = '0;
    else if (issue) wptr_d = wptr_q + ADDR_W'(1);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ITB_IDLE;
    else     state_q <= state_d;
  end

  // Registered RAM write port, pointer and sticky status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      post_cnt_q <= '0;
      wptr_q     <= '0;
      en_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      wrapped_q  <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      post_cnt_q <= post_cnt_d;
      wptr_q     <= wptr_d;
      en_q       <= issue;
      if (issue) begin
        addr_q <= wptr_q;
        data_q <= commit_pc;
      end
      if (clr)                          wrapped_q <= 1'b0;
      else if (issue && (&wptr_q))      wrapped_q <= 1'b1;
      if (clr)       drop_q <= 1'b0;
      else if (lost) drop_q <= 1'b1;
    end
  end

  assign itb_en      = en_q;
  assign itb_addr    = addr_q;
  assign itb_data    = data_q;
  assign itb_wptr    = wptr_q;
  assign itb_wrapped = wrapped_q;
  assign itb_frozen  = (state_q == ITB_FROZEN);
  assign itb_drop    = drop_q;

endmodule : orv64_itb_ctrl

// File: tb/tb_orv64_itb_ctrl.sv
// Scoreboard bench for the ITB write controller, built with a depth-8 buffer
// so the wrap case is short.
module tb_orv64_itb_ctrl;

  localparam int unsigned AW = 3;
  localparam int unsigned PW = 39;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [PW-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_itb_en;
  logic          cfg_itb_mode;
  logic [AW-1:0] cfg_post_trig_cnt;
  logic          trig, clr, commit_valid, commit_is_rvc, dbg_busy;
  logic [PW-1:0] commit_pc;
  logic          itb_en, itb_wrapped, itb_frozen, itb_drop;
  logic [AW-1:0] itb_addr, itb_wptr;
  logic [PW-1:0] itb_data;

  wr_t           exp_q[$];
  logic [AW-1:0] exp_wptr;
  int            vectors    = 0;
  int            miscompares = 0;

  orv64_itb_ctrl #(.ADDR_W(AW), .PC_W(PW)) dut (
    .clk               (clk),
    .rst               (rst),
    .cfg_itb_en        (cfg_itb_en),
    .cfg_itb_mode      (cfg_itb_mode),
    .cfg_post_trig_cnt (cfg_post_trig_cnt),
    .trig              (trig),
    .clr               (clr),
    .commit_valid      (commit_valid),
    .commit_pc         (commit_pc),
    .commit_is_rvc     (commit_is_rvc),
    .dbg_busy          (dbg_busy),
    .itb_en            (itb_en),
    .itb_addr          (itb_addr),
    .itb_data          (itb_data),
    .itb_wptr          (itb_wptr),
    .itb_wrapped       (itb_wrapped),
    .itb_frozen        (itb_frozen),
    .itb_drop          (itb_drop)
  );

  always #5 clk = ~clk;

  // Every RAM write is matched against the oldest expected entry.
  always @(negedge clk) begin
    if (itb_en === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, expected no write", itb_addr, itb_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if ({itb_addr, itb_data} !== {e.addr, e.data}) begin
          miscompares++;
          $display("FAIL write: got addr=%0d data=%h, expected addr=%0d data=%h",
                   itb_addr, itb_data, e.addr, e.data);
        end
      end
    end
  end

  // One clock of stimulus; wr says whether this commit must reach the RAM.
  task automatic step(input logic v, input logic [PW-1:0] pc, input logic rvc,
                      input logic t, input logic busy, input logic c, input bit wr);
    commit_valid  = v;
    commit_pc     = pc;
    commit_is_rvc = rvc;
    trig          = t;
    dbg_busy      = busy;
    clr           = c;
    if (wr) begin
      exp_q.push_back('{addr: exp_wptr, data: pc});
      exp_wptr = exp_wptr + 1'b1;
    end
    @(posedge clk); #1;
    commit_valid = 1'b0;
    trig         = 1'b0;
    dbg_busy     = 1'b0;
    clr          = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // clr, then one IDLE cycle so the controller is back in RUN.
  task automatic restart();
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    exp_wptr = '0;
    idle(1);
  endtask

  task automatic drain(input string name);
    idle(2);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_drain: got %0d writes outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_itb_en = 1'b0; cfg_itb_mode = 1'b0; cfg_post_trig_cnt = '0;
    trig = 1'b0; clr = 1'b0; commit_valid = 1'b0; commit_pc = '0;
    commit_is_rvc = 1'b0; dbg_busy = 1'b0; exp_wptr = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({itb_en, itb_addr, itb_data, itb_wptr, itb_wrapped, itb_frozen, itb_drop} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got en=%b addr=%0d data=%h wptr=%0d wr=%b fz=%b drop=%b, expected all 0",
               itb_en, itb_addr, itb_data, itb_wptr, itb_wrapped, itb_frozen, itb_drop);
    end
    rst = 1'b0;
    cfg_itb_en = 1'b1;
    idle(1);
  endtask

  task automatic test_mode0();
    step(1'b1, 39'h1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 39'h1004, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 39'h1002, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    vectors++;
    if (itb_wptr !== 3'd3) begin
      miscompares++;
      $display("FAIL mode0_wptr: got %0d, expected 3", itb_wptr);
    end
    drain("mode0");
  endtask

  task automatic test_clr_state();
    restart();
    vectors++;
    if ({itb_wptr, itb_wrapped, itb_frozen, itb_drop} !== '0) begin
      miscompares++;
      $display("FAIL clr_state: got wptr=%0d wr=%b fz=%b drop=%b, expected all 0",
               itb_wptr, itb_wrapped, itb_frozen, itb_drop);
    end
  endtask

  task automatic test_mode1();
    cfg_itb_mode = 1'b1;
    restart();
    step(1'b1, 39'h2000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 39'h2004, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    step(1'b1, 39'h2008, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 39'h3000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 39'h3002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (itb_wptr !== 3'd2) begin
      miscompares++;
      $display("FAIL mode1_wptr: got %0d, expected 2", itb_wptr);
    end
    drain("mode1");
    cfg_itb_mode = 1'b0;
  endtask

  task automatic test_wrap();
    restart();
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 39'h4000 + 39'(4 * i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      if (i == 6) begin
        vectors++;
        if ({itb_wptr, itb_wrapped} !== {3'd7, 1'b0}) begin
          miscompares++;
          $display("FAIL prewrap: got wptr=%0d wrapped=%b, expected 7/0", itb_wptr, itb_wrapped);
        end
      end
    end
    vectors++;
    if ({itb_wptr, itb_wrapped} !== {3'd1, 1'b1}) begin
      miscompares++;
      $display("FAIL wrap: got wptr=%0d wrapped=%b, expected 1/1", itb_wptr, itb_wrapped);
    end
    drain("wrap");
  endtask

  task automatic test_post_trig();
    cfg_post_trig_cnt = 3'd2;
    restart();
    step(1'b1, 39'h7000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 39'h7004, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0,       1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (itb_frozen !== 1'b0) begin
      miscompares++;
      $display("FAIL post_not_frozen: got %b, expected 0", itb_frozen);
    end
    for (int i = 0; i < 5; i++)
      step(1'b1, 39'h7008 + 39'(4 * i), 1'b0, 1'b0, 1'b0, 1'b0, i < 2);
    vectors++;
    if ({itb_frozen, itb_wptr} !== {1'b1, 3'd4}) begin
      miscompares++;
      $display("FAIL post_frozen: got frozen=%b wptr=%0d, expected 1/4", itb_frozen, itb_wptr);
    end
    drain("post");
    restart();
    vectors++;
    if ({itb_frozen, itb_wptr} !== {1'b0, 3'd0}) begin
      miscompares++;
      $display("FAIL post_clr: got frozen=%b wptr=%0d, expected 0/0", itb_frozen, itb_wptr);
    end
  endtask

  task automatic test_dbg_busy();
    restart();
    step(1'b1, 39'h5000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 39'h5004, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    vectors++;
    if ({itb_wptr, itb_drop} !== {3'd1, 1'b1}) begin
      miscompares++;
      $display("FAIL busy_drop: got wptr=%0d drop=%b, expected 1/1", itb_wptr, itb_drop);
    end
    step(1'b1, 39'h5008, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    vectors++;
    if ({itb_wptr, itb_drop} !== {3'd2, 1'b1}) begin
      miscompares++;
      $display("FAIL busy_after: got wptr=%0d drop=%b, expected 2/1", itb_wptr, itb_drop);
    end
    drain("busy");
  endtask

  task automatic test_trig_cnt0();
    cfg_post_trig_cnt = 3'd0;
    restart();
    step(1'b1, 39'h6000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    vectors++;
    if (itb_frozen !== 1'b1) begin
      miscompares++;
      $display("FAIL cnt0_frozen: got %b, expected 1", itb_frozen);
    end
    step(1'b1, 39'h6004, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drain("cnt0");
  endtask

  task automatic test_clr_trig();
    // In RUN with a zero post count: an honoured trig would freeze at once.
    restart();
    step(1'b1, 39'h6100, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    exp_wptr = '0;
    vectors++;
    if ({itb_frozen, itb_wptr} !== {1'b0, 3'd0}) begin
      miscompares++;
      $display("FAIL clr_trig: got frozen=%b wptr=%0d, expected 0/0", itb_frozen, itb_wptr);
    end
    idle(1);
    step(1'b1, 39'h6200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drain("clr_trig");
  endtask

  task automatic test_disable();
    restart();
    step(1'b1, 39'h8000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cfg_itb_en = 1'b0;
    idle(1);
    step(1'b1, 39'h8004, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (itb_wptr !== 3'd1) begin
      miscompares++;
      $display("FAIL disable_wptr: got %0d, expected 1", itb_wptr);
    end
    cfg_itb_en = 1'b1;
    idle(1);
    step(1'b1, 39'h9000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drain("disable");
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_clr_state();
    test_mode1();
    test_wrap();
    test_post_trig();
    test_dbg_busy();
    test_trig_cnt0();
    test_clr_trig();
    test_disable();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within 100000 time units");
    $fatal(1, "timeout");
  end

endmodule : tb_orv64_itb_ctrl
